// File: rtl/amstrad_mmu_pkg.sv
// amstrad_mmu_pkg: shared opcodes, constants and helpers for the CPC memory mapper.
package amstrad_mmu_pkg;

  // Gate-array function code in D[7:6] of a 7Fxx write.
  typedef enum logic [1:0] {
    GA_OP_PEN = 2'b00,
    GA_OP_INK = 2'b01,
    GA_OP_RMR = 2'b10,
    GA_OP_MMR = 2'b11
  } ga_op_e;

  localparam int BASE_BLOCK_DEFAULT = 2;
  localparam int PAGE_SHIFT         = 14;

  // Lower ROM sits at the 16K page with only the top page-index bit set.
  function automatic int lrom_page(input int page_w);
    return 1 << (page_w - 1);
  endfunction

  // Mask that folds a requested expansion bank onto the populated banks.
  // ext_size k selects 2^(k+2) banks, clamped to the bank index width.
  function automatic logic [7:0] ext_bank_mask(input logic [2:0] ext_size, input int bank_bits);
    int lg;
    if (ext_size == 3'd0) return 8'd0;
    lg = int'(ext_size) + 2;
    if (lg > bank_bits) lg = bank_bits;
    return 8'((1 << lg) - 1);
  endfunction

endpackage

// File: rtl/amstrad_mmu_page_map.sv
// amstrad_mmu_page_map: combinational 16K page select for the CPC mapper.
// Takes the top two Z80 address bits plus the registered mapper state and
// produces the physical page index and the ROM-overlay flag.
module amstrad_mmu_page_map
  import amstrad_mmu_pkg::*;
#(
  parameter int EXT_BANK_BITS = 5,
  parameter int ROM_BANK_BITS = 8,
  parameter int PAGE_W        = 9,
  parameter int BASE_BLOCK    = BASE_BLOCK_DEFAULT
) (
  input  logic [1:0]               a_hi,
  input  logic                     mem_rd,
  input  logic                     lrom_dis,
  input  logic                     urom_dis,
  input  logic [2:0]               ram_map,
  input  logic [EXT_BANK_BITS-1:0] ext_bank,
  input  logic [ROM_BANK_BITS-1:0] rom_bank,
  output logic                     rom_active,
  output logic [PAGE_W-1:0]        page
);

  localparam logic [PAGE_W-1:0] LROM_PAGE = PAGE_W'(lrom_page(PAGE_W));
  localparam logic [PAGE_W-3:0] BASE_BLK  = (PAGE_W-2)'(BASE_BLOCK);

  // Expansion bank n lives in 64K block n+3; one extra bit so it never wraps.
  logic [EXT_BANK_BITS:0] ext_blk;
  logic                   rom_hit;

  assign ext_blk    = {1'b0, ext_bank} + (EXT_BANK_BITS+1)'(3);
  assign rom_hit    = mem_rd & (((a_hi == 2'b00) & ~lrom_dis) | ((a_hi == 2'b11) & ~urom_dis));
  assign rom_active = rom_hit;

  // Priority page select: ROM overlay first, then the RAM configuration table.
  always_comb begin
    page = {BASE_BLK, a_hi};
    if (rom_hit) begin
      if (!a_hi[1]) page = LROM_PAGE;
      else          page = PAGE_W'({1'b1, rom_bank});
    end else if (ram_map == 3'd2) begin
      page = PAGE_W'({ext_blk, a_hi});
    end else if ((ram_map == 3'd1 || ram_map == 3'd3) && a_hi == 2'b11) begin
      page = PAGE_W'({ext_blk, 2'b11});
    end else if (ram_map == 3'd3 && a_hi == 2'b01) begin
      page = {BASE_BLK, 2'b11};
    end else if (ram_map[2] && a_hi == 2'b01) begin
      page = PAGE_W'({ext_blk, ram_map[1:0]});
    end
  end

endmodule

// File: rtl/amstrad_mmu_xmem.sv
// amstrad_mmu_xmem: CPC memory mapper with RAM expansion up to 4MB.
// Decodes gate-array RMR/MMR writes (7Fxx) and upper-ROM select (DFxx),
// owns the ROM enable state and drives the physical SDRAM address.
// Optional build macro MMU_CONFIG_READBACK_EN adds cfg_rd/cfg_q readback.
module amstrad_mmu_xmem
  import amstrad_mmu_pkg::*;
#(
  parameter int EXT_BANK_BITS = 5,
  parameter int ROM_BANK_BITS = 8,
  parameter int ADDR_W        = 23,
  parameter int BASE_BLOCK    = BASE_BLOCK_DEFAULT
) (
  input  logic                          CLK,
  input  logic                          reset_n,
  input  logic                          io_WR,
  input  logic                          mem_RD,
  input  logic                          plus_mode,
  input  logic [2:0]                    ext_size,
  input  logic [(1<<ROM_BANK_BITS)-1:0] rom_map,
  input  logic [15:0]                   A,
  input  logic [7:0]                    D,
`ifdef MMU_CONFIG_READBACK_EN
  input  logic                          cfg_rd,
  output logic [15:0]                   cfg_q,
`endif
  output logic [ADDR_W-1:0]             ram_A,
  output logic                          rom_active,
  output logic                          cfg_changed
);

  localparam int PAGE_W = ADDR_W - PAGE_SHIFT;

  // Parameter sanity: bank width range and that every page fits in ram_A.
  if (EXT_BANK_BITS < 3 || EXT_BANK_BITS > 6) begin : g_bad_ebb
    $error("EXT_BANK_BITS must be 3..6");
  end
  if (EXT_BANK_BITS + 3 > PAGE_W) begin : g_bad_ext_fit
    $error("ADDR_W too small for expansion block index");
  end
  if (ROM_BANK_BITS + 1 > PAGE_W) begin : g_bad_rom_fit
    $error("ADDR_W too small for upper ROM pages");
  end
  if (BASE_BLOCK >= (1 << (PAGE_W - 2))) begin : g_bad_base
    $error("BASE_BLOCK does not fit in ADDR_W");
  end

  logic [2:0]               ram_map_q,     ram_map_d;
  logic [EXT_BANK_BITS-1:0] ext_bank_q,    ext_bank_d;
  logic [ROM_BANK_BITS-1:0] rom_bank_q,    rom_bank_d;
  logic                     lrom_dis_q,    lrom_dis_d;
  logic                     urom_dis_q,    urom_dis_d;
  logic                     old_wr_q,      old_wr_d;
  logic                     cfg_changed_q, cfg_changed_d;

  logic                     wr_edge;
  logic [EXT_BANK_BITS-1:0] ext_cand;
  logic [EXT_BANK_BITS-1:0] ext_mask;
  logic [ROM_BANK_BITS-1:0] d_rom;
  logic [PAGE_W-1:0]        page;

  // Requested bank: inverted high address bits above the three data bits.
  if (EXT_BANK_BITS > 3) begin : g_ext_hi
    assign ext_cand = {~A[EXT_BANK_BITS+4:8], D[5:3]};
  end else begin : g_ext_lo
    assign ext_cand = D[5:3];
  end

  assign wr_edge  = io_WR & ~old_wr_q;
  assign ext_mask = EXT_BANK_BITS'(ext_bank_mask(ext_size, EXT_BANK_BITS));
  assign d_rom    = ROM_BANK_BITS'(D);

  // Next-state decode of I/O writes; both decodes may fire on one edge.
  always_comb begin
    ram_map_d     = ram_map_q;
    ext_bank_d    = ext_bank_q;
    rom_bank_d    = rom_bank_q;
    lrom_dis_d    = lrom_dis_q;
    urom_dis_d    = urom_dis_q;
    old_wr_d      = io_WR;
    cfg_changed_d = 1'b0;
    if (wr_edge) begin
      if (!A[15]) begin
        if (ga_op_e'(D[7:6]) == GA_OP_RMR) begin
          lrom_dis_d    = D[2];
          urom_dis_d    = D[3];
          cfg_changed_d = 1'b1;
        end else if (ga_op_e'(D[7:6]) == GA_OP_MMR && ext_size != 3'd0) begin
          ram_map_d     = D[2:0];
          ext_bank_d    = ext_cand & ext_mask;
          cfg_changed_d = 1'b1;
        end
      end
      if (!A[13]) begin
        // Absent ROMs fall back to bank 0 unless the Plus firmware selects freely.
        rom_bank_d    = (plus_mode || rom_map[d_rom]) ? d_rom : '0;
        cfg_changed_d = 1'b1;
      end
    end
  end

  // Mapper state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      ram_map_q     <= '0;
      ext_bank_q    <= '0;
      rom_bank_q    <= '0;
      lrom_dis_q    <= 1'b0;
      urom_dis_q    <= 1'b0;
      old_wr_q      <= 1'b0;
      cfg_changed_q <= 1'b0;
    end else begin
      ram_map_q     <= ram_map_d;
      ext_bank_q    <= ext_bank_d;
      rom_bank_q    <= rom_bank_d;
      lrom_dis_q    <= lrom_dis_d;
      urom_dis_q    <= urom_dis_d;
      old_wr_q      <= old_wr_d;
      cfg_changed_q <= cfg_changed_d;
    end
  end

  amstrad_mmu_page_map #(
    .EXT_BANK_BITS(EXT_BANK_BITS),
    .ROM_BANK_BITS(ROM_BANK_BITS),
    .PAGE_W       (PAGE_W),
    .BASE_BLOCK   (BASE_BLOCK)
  ) u_page_map (
    .a_hi      (A[15:14]),
    .mem_rd    (mem_RD),
    .lrom_dis  (lrom_dis_q),
    .urom_dis  (urom_dis_q),
    .ram_map   (ram_map_q),
    .ext_bank  (ext_bank_q),
    .rom_bank  (rom_bank_q),
    .rom_active(rom_active),
    .page      (page)
  );

  assign ram_A       = {page, A[13:0]};
  assign cfg_changed = cfg_changed_q;

`ifdef MMU_CONFIG_READBACK_EN
  logic [15:0] cfg_word_q, cfg_word_d;

  // Readback capture: A[0] picks the ROM bank, otherwise the packed RAM/ROM config.
  always_comb begin
    cfg_word_d = cfg_word_q;
    if (cfg_rd) begin
      if (A[0]) cfg_word_d = 16'(rom_bank_q);
      else      cfg_word_d = {urom_dis_q, lrom_dis_q, ram_map_q, 11'(ext_bank_q)};
    end
  end

  // Readback register, one cycle behind cfg_rd.
  always_ff @(posedge CLK) begin
    if (!reset_n) cfg_word_q <= '0;
    else          cfg_word_q <= cfg_word_d;
  end

  assign cfg_q = cfg_word_q;
`endif

endmodule

// File: tb/tb_amstrad_mmu_xmem.sv
// tb_amstrad_mmu_xmem: scoreboard bench for the CPC memory mapper.
// Driver pushes the expected outputs for every cycle; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_amstrad_mmu_xmem;

  localparam int EBB  = 5;
  localparam int RBB  = 8;
  localparam int AW   = 23;
  localparam int BASE = 2;
  localparam int NBANK_MAX = 1 << EBB;
  localparam int LROM = 1 << (AW - 15);

  logic          CLK = 1'b0;
  logic          reset_n;
  logic          io_WR;
  logic          mem_RD;
  logic          plus_mode;
  logic [2:0]    ext_size;
  logic [255:0]  rom_map;
  logic [15:0]   A;
  logic [7:0]    D;
  logic [AW-1:0] ram_A;
  logic          rom_active;
  logic          cfg_changed;
`ifdef MMU_CONFIG_READBACK_EN
  logic          cfg_rd = 1'b0;
  logic [15:0]   cfg_q;
`endif

  always #5 CLK = ~CLK;

  amstrad_mmu_xmem #(
    .EXT_BANK_BITS(EBB),
    .ROM_BANK_BITS(RBB),
    .ADDR_W       (AW),
    .BASE_BLOCK   (BASE)
  ) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .io_WR      (io_WR),
    .mem_RD     (mem_RD),
    .plus_mode  (plus_mode),
    .ext_size   (ext_size),
    .rom_map    (rom_map),
    .A          (A),
    .D          (D),
`ifdef MMU_CONFIG_READBACK_EN
    .cfg_rd     (cfg_rd),
    .cfg_q      (cfg_q),
`endif
    .ram_A      (ram_A),
    .rom_active (rom_active),
    .cfg_changed(cfg_changed)
  );

  typedef struct packed {
    logic [AW-1:0] ram_a;
    logic          rom_act;
    logic          chg;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: mapper registers as plain integers.
  int m_map = 0, m_ext = 0, m_rom = 0;
  bit m_lrom = 0, m_urom = 0, m_prev = 0, m_chg = 0;

  // Apply one clock edge to the model using the inputs held at that edge.
  task automatic model_edge();
    bit edge_seen;
    int banks, hi;
    m_chg = 0;
    if (!reset_n) begin
      m_map = 0; m_ext = 0; m_rom = 0; m_lrom = 0; m_urom = 0; m_prev = 0;
      return;
    end
    edge_seen = io_WR && !m_prev;
    m_prev = io_WR;
    if (!edge_seen) return;
    if (!A[15]) begin
      if (D[7:6] == 2'b10) begin
        m_lrom = D[2];
        m_urom = D[3];
        m_chg  = 1;
      end else if (D[7:6] == 2'b11 && ext_size != 0) begin
        banks = 1 << (int'(ext_size) + 2);
        if (banks > NBANK_MAX) banks = NBANK_MAX;
        hi    = int'(~A[15:8]) & ((1 << (EBB - 3)) - 1);
        m_map = int'(D[2:0]);
        m_ext = (hi * 8 + int'(D[5:3])) % banks;
        m_chg = 1;
      end
    end
    if (!A[13]) begin
      m_rom = (plus_mode || rom_map[D]) ? int'(D) : 0;
      m_chg = 1;
    end
  endtask

  // Expected outputs for the current inputs and model state.
  function automatic exp_t expect_now();
    exp_t e;
    int   sub, page;
    bit   ra;
    sub = int'(A[15:14]);
    ra  = mem_RD && ((sub == 0 && !m_lrom) || (sub == 3 && !m_urom));
    if (ra)                                        page = (sub == 0) ? LROM : LROM + m_rom;
    else if (m_map == 2)                           page = (m_ext + 3) * 4 + sub;
    else if ((m_map == 1 || m_map == 3) && sub == 3) page = (m_ext + 3) * 4 + 3;
    else if (m_map == 3 && sub == 1)               page = BASE * 4 + 3;
    else if (m_map >= 4 && sub == 1)               page = (m_ext + 3) * 4 + (m_map % 4);
    else                                           page = BASE * 4 + sub;
    e.ram_a   = AW'(page * 16384 + int'(A[13:0]));
    e.rom_act = ra;
    e.chg     = m_chg;
    return e;
  endfunction

  // One clock: update the model at the edge, then drive new inputs and push expectation.
  task automatic step(input string nm, input bit rn, input bit wr, input bit rd,
                      input logic [15:0] a, input logic [7:0] d);
    @(posedge CLK);
    model_edge();
    #1;
    reset_n = rn; io_WR = wr; mem_RD = rd; A = a; D = d;
    exp_q.push_back(expect_now());
    name_q.push_back(nm);
  endtask

  // I/O write: strobe, release (pulse expected), then a quiet cycle.
  task automatic out(input string nm, input logic [15:0] a, input logic [7:0] d);
    step(nm, 1, 1, 0, a, d);
    step({nm, "_post"}, 1, 0, 0, a, d);
    step({nm, "_idle"}, 1, 0, 0, a, d);
  endtask

  task automatic rd(input string nm, input logic [15:0] a);
    step(nm, 1, 0, 1, a, 8'h00);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (ram_A !== e.ram_a || rom_active !== e.rom_act || cfg_changed !== e.chg) begin
          errors++;
          $display("FAIL %s: got ram_A=%h rom_active=%b cfg_changed=%b, want ram_A=%h rom_active=%b cfg_changed=%b",
                   nm, ram_A, rom_active, cfg_changed, e.ram_a, e.rom_act, e.chg);
        end else begin
          $display("txn %0d %s ram_A=%h rom_active=%b cfg_changed=%b", checks, nm, ram_A, rom_active, cfg_changed);
        end
      end
    end
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd8;
    reset_n = 1'b0; io_WR = 1'b0; mem_RD = 1'b0; plus_mode = 1'b0;
    ext_size = 3'd0; rom_map = '1; A = 16'h0; D = 8'h0;

    step("reset0", 0, 0, 0, 16'h0000, 8'h00);
    step("reset1", 0, 0, 0, 16'h0000, 8'h00);

    // Reset state: lower ROM visible on reads, base RAM on writes.
    rd("t1_lrom_read", 16'h0100);
    step("t1_ram_write", 1, 0, 0, 16'h0100, 8'h00);
    rd("t1_c000_read", 16'hC000);

    // 32-bank expansion, RAMmap=2 with bank 8.
    ext_size = 3'd3;
    out("t2_mmr", 16'h7E00, 8'hC2);
    rd("t2_read4000", 16'h4000);
    rd("t2_read8000", 16'h8000);

    // 8-bank expansion folds bank 31 to 7; then no expansion ignores MMR.
    ext_size = 3'd1;
    out("t3_mmr_fold", 16'h7C00, 8'hFF);
    rd("t3_read4000", 16'h4000);
    ext_size = 3'd0;
    out("t3_mmr_none", 16'h7C00, 8'hC1);
    rd("t3_read4000b", 16'h4000);

    // Both ROMs disabled.
    out("t4_rmr_off", 16'h7F00, 8'h8C);
    rd("t4_readC000", 16'hC000);
    rd("t4_read0000", 16'h0000);

    // Upper ROM select with absent ROM, then Plus mode.
    out("t5_rmr_on", 16'h7F00, 8'h80);
    rom_map[7] = 1'b0;
    plus_mode  = 1'b0;
    out("t5_rom7_absent", 16'hDF00, 8'h07);
    rd("t5_readC000", 16'hC000);
    plus_mode = 1'b1;
    out("t5_rom7_plus", 16'hDF00, 8'h07);
    rd("t5_readC000b", 16'hC000);
    plus_mode = 1'b0;
    out("t5_rom5", 16'hDF00, 8'h05);
    rd("t5_readC000c", 16'hC000);

    // Combined decode (A15=0, A13=0) in one write.
    ext_size = 3'd2;
    out("t5_both", 16'h4000, 8'hCB);
    rd("t5_both_rd4000", 16'h4000);
    rd("t5_both_rdC000", 16'hC000);

    // Held io_WR acts once; reset during the hold, re-trigger after release.
    for (int i = 0; i < 10; i++) step("t6_hold", 1, 1, 1, 16'h7F00, 8'h8C);
    step("t6_reset", 0, 1, 1, 16'h7F00, 8'h8C);
    for (int i = 0; i < 4; i++) step("t6_rehold", 1, 1, 1, 16'h7F00, 8'h8C);
    step("t6_release", 1, 0, 1, 16'h0000, 8'h00);
    step("t6_idle", 1, 0, 1, 16'hC000, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        ext_size  = 3'($urandom_range(0, 7));
        plus_mode = 1'($urandom_range(0, 1));
        for (int w = 0; w < 8; w++) rom_map[w*32 +: 32] = $urandom;
      end
      ra  = 16'($urandom);
      rd8 = 8'($urandom);
      if ($urandom_range(0, 1) == 1) ra[15] = 1'b0;
      if ($urandom_range(0, 1) == 1) rd8[7] = 1'b1;
      step("rand", $urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
           1'($urandom_range(0, 1)), ra, rd8);
    end
    step("tail", 1, 0, 0, 16'h0000, 8'h00);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
